// File: rtl/cpu_pkg.sv
// Shared datapath constants for the 16-bit, 4-register pipelined CPU.
package cpu_pkg;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned LINK_REG = 2;
  localparam int unsigned CNT_W    = 16;
endpackage

// File: rtl/regfile_core.sv
// 2-read/1-write register array with async-reset storage and same-cycle write-through bypass.
module regfile_core #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  // The ID stage reads in the same cycle WB writes, so forward the incoming value.
  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (we && (raddr1 == waddr)) rdata1 = wdata;
    if (we && (raddr2 == waddr)) rdata2 = wdata;
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, commit qualification, register file, retire counter, halt flag.
module wb_regfile #(
  parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned LINK_REG = cpu_pkg::LINK_REG,
  parameter int unsigned CNT_W    = cpu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              WB_RegWrite,
  input  logic              WB_MemtoReg,
  input  logic              WB_JLControl,
  input  logic [DATA_W-1:0] WB_PC4,
  input  logic [DATA_W-1:0] WB_ReadDataOfMem,
  input  logic [DATA_W-1:0] WB_ALUResult,
  input  logic [ADDR_W-1:0] WB_WriteRegister,
  input  logic              WB_Valid,
  input  logic              WB_IsHalt,
  input  logic [ADDR_W-1:0] ID_ReadReg1,
  input  logic [ADDR_W-1:0] ID_ReadReg2,
  output logic [DATA_W-1:0] ID_ReadData1,
  output logic [DATA_W-1:0] ID_ReadData2,
  output logic [DATA_W-1:0] WB_WriteData,
  output logic [ADDR_W-1:0] WB_WriteDest,
  output logic [CNT_W-1:0]  num_inst,
  output logic              is_halted
);

  logic             commit;
  logic             retire;
  logic [CNT_W-1:0] num_inst_q, num_inst_d;
  logic             halted_q, halted_d;

  always_comb begin
    WB_WriteData = WB_MemtoReg ? WB_ReadDataOfMem : WB_ALUResult;
    WB_WriteDest = WB_WriteRegister;
    if (WB_JLControl) begin
      WB_WriteData = WB_PC4;
      WB_WriteDest = ADDR_W'(LINK_REG);
    end
  end

  // Once halted, nothing commits or retires; the HLT itself still completes.
  assign retire = WB_Valid & ~halted_q;
  assign commit = WB_RegWrite & retire;

  always_comb begin
    num_inst_d = num_inst_q;
    halted_d   = halted_q;
    if (retire) begin
      num_inst_d = num_inst_q + CNT_W'(1);
      if (WB_IsHalt) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_inst_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      num_inst_q <= num_inst_d;
      halted_q   <= halted_d;
    end
  end

  assign num_inst  = num_inst_q;
  assign is_halted = halted_q;

  regfile_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_regfile_core (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (commit),
    .waddr  (WB_WriteDest),
    .wdata  (WB_WriteData),
    .raddr1 (ID_ReadReg1),
    .raddr2 (ID_ReadReg2),
    .rdata1 (ID_ReadData1),
    .rdata2 (ID_ReadData2)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expectations queued at drive time, popped at observation.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        WB_RegWrite = 1'b0, WB_MemtoReg = 1'b0, WB_JLControl = 1'b0;
  logic [15:0] WB_PC4 = '0, WB_ReadDataOfMem = '0, WB_ALUResult = '0;
  logic [1:0]  WB_WriteRegister = '0;
  logic        WB_Valid = 1'b0, WB_IsHalt = 1'b0;
  logic [1:0]  ID_ReadReg1 = '0, ID_ReadReg2 = '0;
  logic [15:0] ID_ReadData1, ID_ReadData2, WB_WriteData;
  logic [1:0]  WB_WriteDest;
  logic [15:0] num_inst;
  logic        is_halted;

  wb_regfile u_dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .WB_RegWrite     (WB_RegWrite),
    .WB_MemtoReg     (WB_MemtoReg),
    .WB_JLControl    (WB_JLControl),
    .WB_PC4          (WB_PC4),
    .WB_ReadDataOfMem(WB_ReadDataOfMem),
    .WB_ALUResult    (WB_ALUResult),
    .WB_WriteRegister(WB_WriteRegister),
    .WB_Valid        (WB_Valid),
    .WB_IsHalt       (WB_IsHalt),
    .ID_ReadReg1     (ID_ReadReg1),
    .ID_ReadReg2     (ID_ReadReg2),
    .ID_ReadData1    (ID_ReadData1),
    .ID_ReadData2    (ID_ReadData2),
    .WB_WriteData    (WB_WriteData),
    .WB_WriteDest    (WB_WriteDest),
    .num_inst        (num_inst),
    .is_halted       (is_halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [15:0] ref_regs [4];
  logic [15:0] ref_cnt;
  logic        ref_halt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, got, e.exp);
    end
  endtask

  function automatic logic [15:0] exp_rd(input logic [1:0] idx, input logic cm,
                                         input logic [1:0] dst, input logic [15:0] wd);
    return (cm && idx == dst) ? wd : ref_regs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_regs[i] = '0;
    ref_cnt  = '0;
    ref_halt = 1'b0;
  endtask

  // Present one WB transaction, check combinational outputs, then the state after the edge.
  task automatic issue(input string tag, input logic rw, input logic m2r, input logic jl,
                       input logic [15:0] pc4, input logic [15:0] mem, input logic [15:0] alu,
                       input logic [1:0] dest, input logic valid, input logic hlt,
                       input logic [1:0] r1, input logic [1:0] r2);
    logic [15:0] wd;
    logic [1:0]  wdst;
    logic        cm;
    @(negedge clk);
    WB_RegWrite = rw; WB_MemtoReg = m2r; WB_JLControl = jl;
    WB_PC4 = pc4; WB_ReadDataOfMem = mem; WB_ALUResult = alu;
    WB_WriteRegister = dest; WB_Valid = valid; WB_IsHalt = hlt;
    ID_ReadReg1 = r1; ID_ReadReg2 = r2;
    wd   = jl ? pc4 : (m2r ? mem : alu);
    wdst = jl ? 2'd2 : dest;
    cm   = rw && valid && !ref_halt;
    sb_push({tag, "_wdata"}, 32'(wd));
    sb_push({tag, "_wdest"}, 32'(wdst));
    sb_push({tag, "_rd1"}, 32'(exp_rd(r1, cm, wdst, wd)));
    sb_push({tag, "_rd2"}, 32'(exp_rd(r2, cm, wdst, wd)));
    #2;
    sb_pop_check(32'(WB_WriteData));
    sb_pop_check(32'(WB_WriteDest));
    sb_pop_check(32'(ID_ReadData1));
    sb_pop_check(32'(ID_ReadData2));
    @(posedge clk);
    if (cm) ref_regs[wdst] = wd;
    if (valid && !ref_halt) begin
      ref_cnt = ref_cnt + 16'd1;
      if (hlt) ref_halt = 1'b1;
    end
    #1;
    sb_push({tag, "_num_inst"}, 32'(ref_cnt));
    sb_push({tag, "_halted"}, 32'(ref_halt));
    sb_pop_check(32'(num_inst));
    sb_pop_check(32'(is_halted));
  endtask

  task automatic check_regs(input string tag);
    @(negedge clk);
    WB_Valid = 1'b0; WB_RegWrite = 1'b0; WB_IsHalt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ID_ReadReg1 = 2'(i);
      ID_ReadReg2 = 2'(3 - i);
      sb_push($sformatf("%s_reg%0d_p1", tag, i), 32'(ref_regs[i]));
      sb_push($sformatf("%s_reg%0d_p2", tag, 3 - i), 32'(ref_regs[3 - i]));
      #1;
      sb_pop_check(32'(ID_ReadData1));
      sb_pop_check(32'(ID_ReadData2));
    end
  endtask

  // Assert reset between edges and confirm the effect is immediate.
  task automatic do_reset(input string tag);
    @(negedge clk);
    WB_Valid = 1'b0; WB_RegWrite = 1'b0; WB_IsHalt = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      ID_ReadReg1 = 2'(i);
      #1;
      sb_push($sformatf("%s_reg%0d", tag, i), 32'(ref_regs[i]));
      sb_pop_check(32'(ID_ReadData1));
    end
    sb_push({tag, "_num_inst"}, 32'(ref_cnt));
    sb_pop_check(32'(num_inst));
    sb_push({tag, "_halted"}, 32'(ref_halt));
    sb_pop_check(32'(is_halted));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("init");

    // ALU writes, same-cycle bypass on port 1, both ports bypassing together.
    issue("alu_r1", 1, 0, 0, 16'h0, 16'h0, 16'h1234, 2'd1, 1, 0, 2'd1, 2'd0);
    issue("alu_r0", 1, 0, 0, 16'h0, 16'h0, 16'h5A5A, 2'd0, 1, 0, 2'd0, 2'd0);
    issue("load_r3", 1, 1, 0, 16'h0, 16'hBEEF, 16'h1111, 2'd3, 1, 0, 2'd3, 2'd1);
    issue("jal", 1, 1, 1, 16'h0042, 16'h9999, 16'h8888, 2'd0, 1, 0, 2'd2, 2'd0);
    check_regs("after_jal");
    issue("bubble", 1, 0, 0, 16'h0, 16'h0, 16'hFFFF, 2'd1, 0, 1, 2'd1, 2'd1);
    issue("norw", 0, 0, 0, 16'h0, 16'h0, 16'hCAFE, 2'd3, 1, 0, 2'd3, 2'd2);
    check_regs("after_bubble");

    do_reset("midrun");
    check_regs("post_reset");

    // Bring the counter to 16'hFFFE, then retire across the wrap.
    @(negedge clk);
    WB_Valid = 1'b1; WB_RegWrite = 1'b0; WB_IsHalt = 1'b0;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    WB_Valid = 1'b0;
    ref_cnt = ref_cnt + 16'd65534;
    #1;
    check_eq("preload_cnt", 32'(num_inst), 32'(ref_cnt));
    for (int i = 0; i < 3; i++) issue("wrap", 0, 0, 0, 16'h0, 16'h0, 16'h0, 2'd0, 1, 0, 2'd0, 2'd1);
    check_eq("wrap_value", 32'(num_inst), 32'h0001);

    // Halt at count 5; the HLT's own write applies, later writes do not.
    do_reset("pre_halt");
    for (int i = 0; i < 5; i++)
      issue("retire", 1, 0, 0, 16'h0, 16'h0, 16'(16'h0100 + i), 2'(i), 1, 0, 2'(i), 2'd3);
    issue("hlt", 1, 0, 0, 16'h0, 16'h0, 16'h4321, 2'd3, 1, 1, 2'd3, 2'd3);
    check_eq("halt_cnt", 32'(num_inst), 32'd6);
    issue("post_halt_wr", 1, 0, 0, 16'h0, 16'h0, 16'h7777, 2'd1, 1, 0, 2'd1, 2'd1);
    issue("post_halt_hlt", 1, 0, 1, 16'h0055, 16'h0, 16'h0, 2'd1, 1, 1, 2'd2, 2'd0);
    check_regs("halted");
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
